// File: rtl/cpu_pkg.sv
// Shared CPU definitions: forwarding select encoding, ALU operation codes
// and writeback-select codes used by the execute-stage operand logic.
package cpu_pkg;

  // Source of a forwarded EX operand
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,  // registered register-file read data
    FWD_W    = 2'b01,  // writeback-stage result
    FWD_M    = 2'b10   // memory-stage ALU result
  } fwd_sel_t;

  // ALU operation codes carried on ALUctrl
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_SRL   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  // Writeback select codes carried on ResultSrc
  localparam logic [1:0] RESULTSRC_ALU = 2'b00;
  localparam logic [1:0] RESULTSRC_MEM = 2'b01;
  localparam logic [1:0] RESULTSRC_PC4 = 2'b10;

endpackage

// File: rtl/ex_fwd_mux.sv
// Forwarding selector for one EX source operand. The memory stage wins over
// writeback when both target the same register; register x0 is never
// forwarded because it is hard-wired to zero.
module ex_fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_i,
  input  logic [DATA_WIDTH-1:0]     reg_val_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic                      regwrite_m_i,
  input  logic [DATA_WIDTH-1:0]     alu_result_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      regwrite_w_i,
  input  logic [DATA_WIDTH-1:0]     result_w_i,
  output logic [1:0]                sel_o,
  output logic [DATA_WIDTH-1:0]     val_o
);

  fwd_sel_t sel;
  logic     hit_m;
  logic     hit_w;

  assign hit_m = regwrite_m_i && (rd_m_i != '0) && (rd_m_i == rs_i);
  assign hit_w = regwrite_w_i && (rd_w_i != '0) && (rd_w_i == rs_i);

  // Pick the youngest in-flight producer of rs, else the register file value
  always_comb begin
    sel   = FWD_NONE;
    val_o = reg_val_i;
    if (hit_m) begin
      sel   = FWD_M;
      val_o = alu_result_m_i;
    end else if (hit_w) begin
      sel   = FWD_W;
      val_o = result_w_i;
    end
  end

  assign sel_o = sel;

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register plus ALU operand selection.
// Build option: define EX_FORWARDING_EN to resolve EX data hazards by
// forwarding from the MEM and WB stages; without it the registered
// register-file data is used directly and the hazard unit must stall on
// every RAW dependence.
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CONTROL_WIDTH  = 3,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic [CONTROL_WIDTH-1:0]  ALUctrl_i,
  input  logic                      ALUSrc_i,
  input  logic [DATA_WIDTH-1:0]     RD1_i,
  input  logic [DATA_WIDTH-1:0]     RD2_i,
  input  logic [DATA_WIDTH-1:0]     ImmExt_i,
  input  logic [PC_WIDTH-1:0]       PC_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_i,
  input  logic                      RegWrite_i,
  input  logic                      MemWrite_i,
  input  logic                      Branch_i,
  input  logic                      Jump_i,
  input  logic [1:0]                ResultSrc_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  input  logic                      RegWriteM_i,
  input  logic [DATA_WIDTH-1:0]     ALUResultM_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
  input  logic                      RegWriteW_i,
  input  logic [DATA_WIDTH-1:0]     ResultW_i,
  output logic                      valid_o,
  output logic [CONTROL_WIDTH-1:0]  ALUctrl_o,
  output logic [DATA_WIDTH-1:0]     SrcA_o,
  output logic [DATA_WIDTH-1:0]     SrcB_o,
  output logic [DATA_WIDTH-1:0]     WriteData_o,
  output logic [PC_WIDTH-1:0]       PC_o,
  output logic [DATA_WIDTH-1:0]     ImmExt_o,
  output logic [REG_ADDR_WIDTH-1:0] Rd_o,
  output logic [REG_ADDR_WIDTH-1:0] Rs1_o,
  output logic [REG_ADDR_WIDTH-1:0] Rs2_o,
  output logic                      RegWrite_o,
  output logic                      MemWrite_o,
  output logic                      Branch_o,
  output logic                      Jump_o,
  output logic [1:0]                ResultSrc_o
);

  logic                      valid_q,     valid_d;
  logic [CONTROL_WIDTH-1:0]  aluctrl_q,   aluctrl_d;
  logic                      alusrc_q,    alusrc_d;
  logic [DATA_WIDTH-1:0]     rd1_q,       rd1_d;
  logic [DATA_WIDTH-1:0]     rd2_q,       rd2_d;
  logic [DATA_WIDTH-1:0]     imm_q,       imm_d;
  logic [PC_WIDTH-1:0]       pc_q,        pc_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q,       rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_q,       rs2_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;
  logic                      regwrite_q,  regwrite_d;
  logic                      memwrite_q,  memwrite_d;
  logic                      branch_q,    branch_d;
  logic                      jump_q,      jump_d;
  logic [1:0]                resultsrc_q, resultsrc_d;

  logic [DATA_WIDTH-1:0]     src_a;
  logic [DATA_WIDTH-1:0]     fwd_rd2;

  // Next state: flush inserts a bubble (even under stall), stall holds,
  // otherwise capture decode; state-changing controls are valid-qualified
  always_comb begin
    valid_d     = valid_q;
    aluctrl_d   = aluctrl_q;
    alusrc_d    = alusrc_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    regwrite_d  = regwrite_q;
    memwrite_d  = memwrite_q;
    branch_d    = branch_q;
    jump_d      = jump_q;
    resultsrc_d = resultsrc_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      aluctrl_d   = '0;
      alusrc_d    = 1'b0;
      rd1_d       = '0;
      rd2_d       = '0;
      imm_d       = '0;
      pc_d        = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      regwrite_d  = 1'b0;
      memwrite_d  = 1'b0;
      branch_d    = 1'b0;
      jump_d      = 1'b0;
      resultsrc_d = '0;
    end else if (!stall_i) begin
      valid_d     = valid_i;
      aluctrl_d   = ALUctrl_i;
      alusrc_d    = ALUSrc_i;
      rd1_d       = RD1_i;
      rd2_d       = RD2_i;
      imm_d       = ImmExt_i;
      pc_d        = PC_i;
      rs1_d       = Rs1_i;
      rs2_d       = Rs2_i;
      rd_d        = Rd_i;
      regwrite_d  = valid_i & RegWrite_i;
      memwrite_d  = valid_i & MemWrite_i;
      branch_d    = valid_i & Branch_i;
      jump_d      = valid_i & Jump_i;
      resultsrc_d = ResultSrc_i;
    end
  end

  // ID/EX register bank with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= 1'b0;
      aluctrl_q   <= '0;
      alusrc_q    <= 1'b0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      resultsrc_q <= '0;
    end else begin
      valid_q     <= valid_d;
      aluctrl_q   <= aluctrl_d;
      alusrc_q    <= alusrc_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      branch_q    <= branch_d;
      jump_q      <= jump_d;
      resultsrc_q <= resultsrc_d;
    end
  end

`ifdef EX_FORWARDING_EN
  // Forwarding re-evaluates every cycle from the registered source indices
  // and the live M/W buses, so it keeps tracking while the stage is stalled
  logic [1:0] fwd_a_sel_unused;
  logic [1:0] fwd_b_sel_unused;

  ex_fwd_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_a (
    .rs_i          (rs1_q),
    .reg_val_i     (rd1_q),
    .rd_m_i        (RdM_i),
    .regwrite_m_i  (RegWriteM_i),
    .alu_result_m_i(ALUResultM_i),
    .rd_w_i        (RdW_i),
    .regwrite_w_i  (RegWriteW_i),
    .result_w_i    (ResultW_i),
    .sel_o         (fwd_a_sel_unused),
    .val_o         (src_a)
  );

  ex_fwd_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_b (
    .rs_i          (rs2_q),
    .reg_val_i     (rd2_q),
    .rd_m_i        (RdM_i),
    .regwrite_m_i  (RegWriteM_i),
    .alu_result_m_i(ALUResultM_i),
    .rd_w_i        (RdW_i),
    .regwrite_w_i  (RegWriteW_i),
    .result_w_i    (ResultW_i),
    .sel_o         (fwd_b_sel_unused),
    .val_o         (fwd_rd2)
  );
`else
  // No forwarding: operands come straight from the pipeline register and
  // the M/W buses are deliberately left unused
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{RdM_i, RegWriteM_i, ALUResultM_i,
                               RdW_i, RegWriteW_i, ResultW_i};
  assign src_a   = rd1_q;
  assign fwd_rd2 = rd2_q;
`endif

  assign SrcA_o      = src_a;
  assign WriteData_o = fwd_rd2;
  assign SrcB_o      = alusrc_q ? imm_q : fwd_rd2;

  assign valid_o     = valid_q;
  assign ALUctrl_o   = aluctrl_q;
  assign PC_o        = pc_q;
  assign ImmExt_o    = imm_q;
  assign Rd_o        = rd_q;
  assign Rs1_o       = rs1_q;
  assign Rs2_o       = rs2_q;
  assign RegWrite_o  = regwrite_q;
  assign MemWrite_o  = memwrite_q;
  assign Branch_o    = branch_q;
  assign Jump_o      = jump_q;
  assign ResultSrc_o = resultsrc_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: snapshot model of the EX slot plus
// spec-level operand rules, checked every negative clock edge, together with
// directed vectors carrying hand-computed expectations.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, valid;
  logic [2:0]  aluctrl;
  logic        alusrc;
  logic [31:0] rd1, rd2, imm, pc;
  logic [4:0]  rs1, rs2, rd;
  logic        regwrite, memwrite, branch, jump;
  logic [1:0]  resultsrc;
  logic [4:0]  rdm, rdw;
  logic        regwritem, regwritew;
  logic [31:0] aluresm, resultw;

  logic        valid_o;
  logic [2:0]  aluctrl_o;
  logic [31:0] srca_o, srcb_o, wdata_o, pc_o, imm_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic        regwrite_o, memwrite_o, branch_o, jump_o;
  logic [1:0]  resultsrc_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush),
    .valid_i(valid), .ALUctrl_i(aluctrl), .ALUSrc_i(alusrc),
    .RD1_i(rd1), .RD2_i(rd2), .ImmExt_i(imm), .PC_i(pc),
    .Rs1_i(rs1), .Rs2_i(rs2), .Rd_i(rd),
    .RegWrite_i(regwrite), .MemWrite_i(memwrite), .Branch_i(branch),
    .Jump_i(jump), .ResultSrc_i(resultsrc),
    .RdM_i(rdm), .RegWriteM_i(regwritem), .ALUResultM_i(aluresm),
    .RdW_i(rdw), .RegWriteW_i(regwritew), .ResultW_i(resultw),
    .valid_o(valid_o), .ALUctrl_o(aluctrl_o), .SrcA_o(srca_o),
    .SrcB_o(srcb_o), .WriteData_o(wdata_o), .PC_o(pc_o),
    .ImmExt_o(imm_o), .Rd_o(rd_o), .Rs1_o(rs1_o), .Rs2_o(rs2_o),
    .RegWrite_o(regwrite_o), .MemWrite_o(memwrite_o),
    .Branch_o(branch_o), .Jump_o(jump_o), .ResultSrc_o(resultsrc_o)
  );

  // Contents of the EX slot as the model sees it
  typedef struct packed {
    logic        valid;
    logic [2:0]  alu;
    logic        alusrc;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw, br, jp;
    logic [1:0]  rsrc;
  } ex_t;

  ex_t m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand value the ALU must see for source index rs whose file value was v
  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] v);
`ifdef EX_FORWARDING_EN
    if (regwritem && rdm != 0 && rdm == rs) return aluresm;
    if (regwritew && rdw != 0 && rdw == rs) return resultw;
`endif
    return v;
  endfunction

  // Slot model: bubble on flush, hold on stall, else take the decode bundle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) m <= '0;
    else if (!stall) begin
      m <= '{valid: valid, alu: aluctrl, alusrc: alusrc, rd1: rd1, rd2: rd2,
             imm: imm, pc: pc, rs1: rs1, rs2: rs2, rd: rd,
             rw: valid & regwrite, mw: valid & memwrite,
             br: valid & branch, jp: valid & jump, rsrc: resultsrc};
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [31:0] wd;
    wd = operand(m.rs2, m.rd2);
    chk("valid_o", valid_o, m.valid);
    chk("ALUctrl_o", aluctrl_o, m.alu);
    chk("SrcA_o", srca_o, operand(m.rs1, m.rd1));
    chk("SrcB_o", srcb_o, m.alusrc ? m.imm : wd);
    chk("WriteData_o", wdata_o, wd);
    chk("PC_o", pc_o, m.pc);
    chk("ImmExt_o", imm_o, m.imm);
    chk("Rd/Rs1/Rs2_o", {rd_o, rs1_o, rs2_o}, {m.rd, m.rs1, m.rs2});
    chk("ctrl_o", {regwrite_o, memwrite_o, branch_o, jump_o, resultsrc_o},
        {m.rw, m.mw, m.br, m.jp, m.rsrc});
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; valid = 0; aluctrl = 0; alusrc = 0;
    rd1 = 0; rd2 = 0; imm = 0; pc = 0; rs1 = 0; rs2 = 0; rd = 0;
    regwrite = 0; memwrite = 0; branch = 0; jump = 0; resultsrc = 0;
    rdm = 0; rdw = 0; regwritem = 0; regwritew = 0; aluresm = 0; resultw = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid_o"}, valid_o, 0);
    chk({tag, " SrcA_o"}, srca_o, 0);
    chk({tag, " SrcB_o"}, srcb_o, 0);
    chk({tag, " WriteData_o"}, wdata_o, 0);
    chk({tag, " ctrl_o"}, {aluctrl_o, regwrite_o, memwrite_o, branch_o, jump_o, resultsrc_o}, 0);
    chk({tag, " PC_o"}, pc_o, 0);
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1;
    cycle();

    // Simple load, no hazards
    valid = 1; rd1 = 5; rd2 = 7; alusrc = 0; aluctrl = 3'b000;
    rs1 = 1; rs2 = 2; rd = 4; regwrite = 1; pc = 32'h100; imm = 3;
    cycle();
    chk("load SrcA", srca_o, 5);
    chk("load SrcB", srcb_o, 7);
    chk("load ALUctrl", aluctrl_o, 0);
    chk("load valid", valid_o, 1);
    chk("load RegWrite", regwrite_o, 1);
    chk("load PC", pc_o, 32'h100);

    // Double hazard on Rs1: M and W both target x3
    rs1 = 3; rd1 = 32'h11; rdm = 3; regwritem = 1; aluresm = 32'hAA;
    rdw = 3; regwritew = 1; resultw = 32'hBB;
    cycle();
`ifdef EX_FORWARDING_EN
    chk("hazard M prio", srca_o, 32'hAA);
`else
    chk("hazard no-fwd", srca_o, 32'h11);
`endif
    regwritem = 0;
    #1;
`ifdef EX_FORWARDING_EN
    chk("hazard W only", srca_o, 32'hBB);
`else
    chk("hazard W no-fwd", srca_o, 32'h11);
`endif

    // x0 must never be forwarded
    regwritem = 1; rs1 = 0; rdm = 0; rdw = 0; rd1 = 32'h22;
    cycle();
    chk("x0 SrcA", srca_o, 32'h22);

    // Store: immediate on SrcB, forwarded store data on WriteData
    alusrc = 1; imm = 32'h10; rs2 = 6; rd2 = 32'h99; rdw = 6;
    regwritew = 1; resultw = 32'h55; regwritem = 0;
    memwrite = 1; regwrite = 0; pc = 32'h104;
    cycle();
    chk("store SrcB", srcb_o, 32'h10);
`ifdef EX_FORWARDING_EN
    chk("store WriteData", wdata_o, 32'h55);
`else
    chk("store WriteData", wdata_o, 32'h99);
`endif
    chk("store MemWrite", memwrite_o, 1);

    // Stall two cycles while decode inputs and W result change
    stall = 1; rd1 = 32'hDEAD; imm = 32'h77; pc = 32'h200; memwrite = 0; resultw = 32'h66;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("stall ImmExt", imm_o, 32'h10);
      chk("stall PC", pc_o, 32'h104);
      chk("stall MemWrite", memwrite_o, 1);
      chk("stall valid", valid_o, 1);
`ifdef EX_FORWARDING_EN
      chk("stall WriteData", wdata_o, 32'h66);
`else
      chk("stall WriteData", wdata_o, 32'h99);
`endif
      rd2 = 32'hBEEF;
    end

    // Flush wins over stall
    flush = 1; regwritew = 0;
    cycle();
    chk("flush valid", valid_o, 0);
    chk("flush RegWrite", regwrite_o, 0);
    chk("flush MemWrite", memwrite_o, 0);
    chk("flush SrcB", srcb_o, 0);

    // Invalid slot cannot write state
    flush = 0; stall = 0; valid = 0; regwrite = 1; memwrite = 1;
    branch = 1; jump = 1; resultsrc = 2'b10;
    cycle();
    chk("invalid ctrl", {valid_o, regwrite_o, memwrite_o, branch_o, jump_o}, 0);
    chk("invalid ResultSrc", resultsrc_o, 2'b10);

    // Valid op, then asynchronous reset between edges
    valid = 1; aluctrl = 3'b111; resultsrc = 2'b01; rd1 = 32'h1234; alusrc = 0; rd2 = 32'h4321;
    rs1 = 9; rs2 = 10;
    cycle();
    chk("pre-reset ctrl", {aluctrl_o, branch_o, jump_o, resultsrc_o}, {3'b111, 1'b1, 1'b1, 2'b01});
    #2;
    rst_n = 0;
    #1;
    chk_all_zero("async reset");
    @(negedge clk);
    rst_n = 1;
    cycle();

    // Mixed vectors exercising forwarding, stall and flush combinations
    for (int i = 0; i < 12; i++) begin
      valid = 1; aluctrl = 3'(i); alusrc = (i % 8) >= 4;
      rs1 = 5'(i % 4); rs2 = 5'((i + 1) % 4); rd = 5'(i);
      rd1 = 32'h1000 + 32'(i); rd2 = 32'h2000 + 32'(i); imm = 32'h3000 + 32'(i);
      pc = 32'h400 + 32'(4 * i);
      regwrite = i[0]; memwrite = i[1]; branch = i[2]; jump = i[3];
      resultsrc = 2'(i % 3);
      rdm = 5'(i % 3); rdw = 5'((i / 2) % 4);
      regwritem = i[0]; regwritew = i[1];
      aluresm = 32'hA000 + 32'(i); resultw = 32'hB000 + 32'(i);
      stall = (i == 5); flush = (i == 9);
      cycle();
    end
    stall = 0; flush = 0;
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
